// File: rtl/deser_pkg.sv
// Shared constants, length-width helper and receive-state encoding for the
// serial-to-queue path.
package deser_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/fila_param.sv
// First-word-fall-through queue of DEPTH words with explicit pointer wrap,
// so DEPTH need not be a power of two.
module fila_param
    import deser_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enqueue,
    input  logic                           dequeue,
    input  logic                           flush,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              head,
    output logic [len_width(DEPTH)-1:0]    len,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = len_width(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LEN_W-1:0]  len_r;
    logic              do_deq_s;
    logic              do_enq_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // A full queue still accepts a word when the same edge pops one.
    always_comb begin
        do_deq_s = dequeue & ~empty & ~flush;
        do_enq_s = enqueue & ~flush & (~full | do_deq_s);
    end

    // Storage array; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
        end else begin
            if (do_enq_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (do_deq_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            if (do_enq_s && !do_deq_s) begin
                len_r <= len_r + LEN_W'(1);
            end else if (do_deq_s && !do_enq_s) begin
                len_r <= len_r - LEN_W'(1);
            end else begin
                len_r <= len_r;
            end
        end
    end

    // Status and head decode from registered occupancy.
    always_comb begin
        len   = len_r;
        empty = (len_r == {LEN_W{1'b0}});
        full  = (len_r == LEN_W'(DEPTH));
        head  = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
    end

endmodule

// File: rtl/deser_fila_param.sv
// Serial-to-word assembler feeding an internal FWFT queue, with selectable
// bit order, flush, almost-full flag and saturating drop counter.
module deser_fila_param
    import deser_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int AFULL_LVL = 6,
    parameter int OVF_W     = 8
) (
    input  logic                         clock1M,
    input  logic                         reset,
    input  logic                         data_in,
    input  logic                         write_in,
    input  logic                         dequeue_in,
    input  logic                         flush_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   len_out,
    output logic                         status_out,
    output logic                         almost_full_out,
    output logic [OVF_W-1:0]             overflow_cnt_out
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int LEN_W = len_width(DEPTH);

    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_next_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [OVF_W-1:0]  ovf_cnt_r;
    rx_state_t         rx_state_s;
    logic              last_bit_s;
    logic              word_done_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LEN_W-1:0]  len_s;

    // Bit-order mux and word-completion decode; the final bit is part of the word.
    always_comb begin
        rx_state_s   = (bit_cnt_r == {CNT_W{1'b0}}) ? RX_IDLE : RX_SHIFT;
        last_bit_s   = (bit_cnt_r == CNT_W'(DATA_W - 1));
        if (MSB_FIRST) begin
            shreg_next_s = {shreg_r[DATA_W-2:0], data_in};
        end else begin
            shreg_next_s = {data_in, shreg_r[DATA_W-1:1]};
        end
        word_done_s  = write_in & ~flush_in & last_bit_s;
        drop_s       = word_done_s & fifo_full_s & ~dequeue_in;
    end

    // Shift register and bit counter; an idle strobe holds the partial word.
    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            shreg_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_in) begin
            shreg_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (write_in) begin
            shreg_r <= shreg_next_s;
            case (rx_state_s)
                RX_IDLE:  bit_cnt_r <= CNT_W'(1);
                RX_SHIFT: bit_cnt_r <= last_bit_s ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1);
                default:  bit_cnt_r <= {CNT_W{1'b0}};
            endcase
        end else begin
            shreg_r   <= shreg_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Dropped-word counter survives flush and saturates at all-ones.
    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            ovf_cnt_r <= {OVF_W{1'b0}};
        end else if (drop_s && (ovf_cnt_r != {OVF_W{1'b1}})) begin
            ovf_cnt_r <= ovf_cnt_r + OVF_W'(1);
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    fila_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fila (
        .clk     (clock1M),
        .rst     (reset),
        .enqueue (word_done_s),
        .dequeue (dequeue_in),
        .flush   (flush_in),
        .wdata   (shreg_next_s),
        .head    (data_out),
        .len     (len_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Flags derive only from the registered occupancy, so they cannot glitch.
    always_comb begin
        len_out          = len_s;
        valid_out        = ~fifo_empty_s;
        status_out       = fifo_full_s;
        almost_full_out  = (32'(len_s) >= 32'(AFULL_LVL));
        overflow_cnt_out = ovf_cnt_r;
    end

endmodule

// File: tb/tb_deser_fila_param.sv
// Directed bench: three builds (MSB-first, LSB-first, DEPTH=5) share one
// stimulus bus; each scenario checks the build it targets.
module tb_deser_fila_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic wr  = 1'b0;
    logic deq = 1'b0;
    logic fl  = 1'b0;

    logic [7:0] d_m, d_l, d_5;
    logic       v_m, v_l, v_5;
    logic [3:0] l_m, l_l;
    logic [2:0] l_5;
    logic       s_m, s_l, s_5;
    logic       a_m, a_l, a_5;
    logic [7:0] o_m, o_l, o_5;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    deser_fila_param #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(1'b1), .AFULL_LVL(6), .OVF_W(8)) dut_m (
        .clock1M(clk), .reset(rst), .data_in(din), .write_in(wr), .dequeue_in(deq), .flush_in(fl),
        .data_out(d_m), .valid_out(v_m), .len_out(l_m), .status_out(s_m),
        .almost_full_out(a_m), .overflow_cnt_out(o_m));

    deser_fila_param #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(1'b0), .AFULL_LVL(6), .OVF_W(8)) dut_l (
        .clock1M(clk), .reset(rst), .data_in(din), .write_in(wr), .dequeue_in(deq), .flush_in(fl),
        .data_out(d_l), .valid_out(v_l), .len_out(l_l), .status_out(s_l),
        .almost_full_out(a_l), .overflow_cnt_out(o_l));

    deser_fila_param #(.DATA_W(8), .DEPTH(5), .MSB_FIRST(1'b1), .AFULL_LVL(4), .OVF_W(8)) dut_5 (
        .clock1M(clk), .reset(rst), .data_in(din), .write_in(wr), .dequeue_in(deq), .flush_in(fl),
        .data_out(d_5), .valid_out(v_5), .len_out(l_5), .status_out(s_5),
        .almost_full_out(a_5), .overflow_cnt_out(o_5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din = 1'b0; wr = 1'b0; deq = 1'b0; fl = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    // Sends w MSB-first; optionally raises dequeue on the final bit's edge.
    task automatic send_word(input logic [7:0] w, input logic deq_last);
        for (int i = 7; i >= 0; i--) begin
            din = w[i];
            wr  = 1'b1;
            deq = (i == 0) ? deq_last : 1'b0;
            tick();
        end
        wr = 1'b0; deq = 1'b0; din = 1'b0;
    endtask

    task automatic pop();
        deq = 1'b1;
        tick();
        deq = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (v_m !== 1'b0) begin failed++; $display("FAIL reset_valid: got %0b exp 0", v_m); end
        tests++; if (d_m !== 8'h00) begin failed++; $display("FAIL reset_data: got %h exp 00", d_m); end
        tests++; if (l_m !== 4'd0) begin failed++; $display("FAIL reset_len: got %0d exp 0", l_m); end
        tests++; if ({s_m, a_m} !== 2'b00) begin failed++; $display("FAIL reset_flags: got %b exp 00", {s_m, a_m}); end
        tests++; if (o_m !== 8'd0) begin failed++; $display("FAIL reset_ovf: got %0d exp 0", o_m); end
    endtask

    task automatic test_bit_order();
        logic [7:0] bits;
        bits = 8'hB2;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            din = bits[i];
            wr  = 1'b1;
            tick();
            if (i == 1) begin
                tests++; if (v_m !== 1'b0) begin failed++; $display("FAIL partial_not_valid: got %0b exp 0", v_m); end
            end
        end
        wr = 1'b0;
        tests++; if (v_m !== 1'b1) begin failed++; $display("FAIL msb_valid: got %0b exp 1", v_m); end
        tests++; if (d_m !== 8'hB2) begin failed++; $display("FAIL msb_data: got %h exp b2", d_m); end
        tests++; if (l_m !== 4'd1) begin failed++; $display("FAIL msb_len: got %0d exp 1", l_m); end
        tests++; if (d_l !== 8'h4D) begin failed++; $display("FAIL lsb_data: got %h exp 4d", d_l); end
        pop();
        tests++; if (v_l !== 1'b0) begin failed++; $display("FAIL lsb_pop_valid: got %0b exp 0", v_l); end
        tests++; if (d_l !== 8'h00) begin failed++; $display("FAIL lsb_pop_data: got %h exp 00", d_l); end
        tests++; if (l_l !== 4'd0) begin failed++; $display("FAIL lsb_pop_len: got %0d exp 0", l_l); end
        pop();
        tests++; if (l_l !== 4'd0) begin failed++; $display("FAIL empty_pop_len: got %0d exp 0", l_l); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            send_word(8'(i), 1'b0);
            tests++; if (l_m !== 4'(i)) begin failed++; $display("FAIL fill_len%0d: got %0d exp %0d", i, l_m, i); end
            tests++; if (a_m !== (i >= 6)) begin failed++; $display("FAIL fill_afull%0d: got %0b exp %0b", i, a_m, (i >= 6)); end
            tests++; if (s_m !== (i == 8)) begin failed++; $display("FAIL fill_full%0d: got %0b exp %0b", i, s_m, (i == 8)); end
        end
        send_word(8'hFF, 1'b0);
        tests++; if (o_m !== 8'd1) begin failed++; $display("FAIL ovf_cnt: got %0d exp 1", o_m); end
        tests++; if (l_m !== 4'd8) begin failed++; $display("FAIL ovf_len: got %0d exp 8", l_m); end
        for (int i = 1; i <= 8; i++) begin
            tests++; if (d_m !== 8'(i)) begin failed++; $display("FAIL drain_order%0d: got %h exp %h", i, d_m, 8'(i)); end
            pop();
        end
        tests++; if (v_m !== 1'b0) begin failed++; $display("FAIL drain_empty: got %0b exp 0", v_m); end
    endtask

    task automatic test_full_dequeue();
        do_reset();
        for (int i = 1; i <= 8; i++) send_word(8'(i), 1'b0);
        send_word(8'hFF, 1'b1);
        tests++; if (l_m !== 4'd8) begin failed++; $display("FAIL fdq_len: got %0d exp 8", l_m); end
        tests++; if (o_m !== 8'd0) begin failed++; $display("FAIL fdq_ovf: got %0d exp 0", o_m); end
        tests++; if (d_m !== 8'h02) begin failed++; $display("FAIL fdq_head: got %h exp 02", d_m); end
        for (int i = 2; i <= 8; i++) pop();
        tests++; if (d_m !== 8'hFF) begin failed++; $display("FAIL fdq_tail: got %h exp ff", d_m); end
    endtask

    task automatic test_flush();
        do_reset();
        send_word(8'h11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; wr = 1'b1;
            tick();
        end
        din = 1'b1; wr = 1'b1; deq = 1'b1; fl = 1'b1;
        tick();
        wr = 1'b0; deq = 1'b0; fl = 1'b0;
        tests++; if (l_m !== 4'd0) begin failed++; $display("FAIL flush_len: got %0d exp 0", l_m); end
        tests++; if (v_m !== 1'b0) begin failed++; $display("FAIL flush_valid: got %0b exp 0", v_m); end
        send_word(8'hA5, 1'b0);
        tests++; if (d_m !== 8'hA5) begin failed++; $display("FAIL flush_clean: got %h exp a5", d_m); end
        tests++; if (l_m !== 4'd1) begin failed++; $display("FAIL flush_next_len: got %0d exp 1", l_m); end
    endtask

    task automatic test_wrap_depth5();
        logic [7:0] q[$];
        logic [7:0] w;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w = 8'(8'h30 + i);
            send_word(w, 1'b0);
            q.push_back(w);
        end
        tests++; if (s_5 !== 1'b1) begin failed++; $display("FAIL d5_full: got %0b exp 1", s_5); end
        for (int k = 0; k < 12; k++) begin
            w = 8'(8'hA0 + k);
            send_word(w, 1'b1);
            void'(q.pop_front());
            q.push_back(w);
            tests++; if (d_5 !== q[0]) begin failed++; $display("FAIL d5_head%0d: got %h exp %h", k, d_5, q[0]); end
            tests++; if (l_5 !== 3'd5) begin failed++; $display("FAIL d5_len%0d: got %0d exp 5", k, l_5); end
        end
        for (int i = 0; i < 5; i++) begin
            tests++; if (d_5 !== q[i]) begin failed++; $display("FAIL d5_drain%0d: got %h exp %h", i, d_5, q[i]); end
            pop();
        end
        tests++; if (v_5 !== 1'b0) begin failed++; $display("FAIL d5_empty: got %0b exp 0", v_5); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) send_word(8'(8'h50 + i), 1'b0);
        tests++; if (o_5 !== 8'd1) begin failed++; $display("FAIL ar_ovf_pre: got %0d exp 1", o_5); end
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if ({v_5, l_5, s_5, a_5} !== 6'b0) begin failed++; $display("FAIL ar_flags: got %b exp 000000", {v_5, l_5, s_5, a_5}); end
        tests++; if (d_5 !== 8'h00) begin failed++; $display("FAIL ar_data: got %h exp 00", d_5); end
        tests++; if (o_5 !== 8'd0) begin failed++; $display("FAIL ar_ovf: got %0d exp 0", o_5); end
        rst = 1'b0;
        tick();
        send_word(8'hC3, 1'b0);
        tests++; if (d_5 !== 8'hC3) begin failed++; $display("FAIL ar_clean_word: got %h exp c3", d_5); end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_fill_overflow();
        test_full_dequeue();
        test_flush();
        test_wrap_depth5();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/deser_fila_param.md
Name: deser_fila_param

Overview:
Parametrised, single-clock successor to the deserializer-plus-queue path. It assembles serial bits into DATA_W-bit words and pushes each complete word into an internal DEPTH-entry first-word-fall-through queue. Added behaviour includes selectable bit order, a flush input, an almost-full flag and a saturating overflow counter. It replaces the glue between deserializer and queue; no divided clocks are needed inside.

Parameters:
DATA_W, 8, word width in bits (>=2)
DEPTH, 8, queue entries (>=2, need not be a power of two)
MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_W-1]; 0 = first bit lands in bit 0
AFULL_LVL, 6, almost_full_out asserted when len_out >= AFULL_LVL
OVF_W, 8, overflow counter width

Ports:
clock1M  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
data_in  in  1  serial data bit
write_in  in  1  bit strobe; data_in is sampled on every edge where write_in=1
dequeue_in  in  1  pops the head word when not empty
flush_in  in  1  synchronous clear of the queue and the partial word
data_out  out  DATA_W  head of queue; 0 when empty
valid_out  out  1  queue not empty
len_out  out  $clog2(DEPTH+1)  current occupancy
status_out  out  1  queue full (len_out==DEPTH)
almost_full_out  out  1  len_out >= AFULL_LVL
overflow_cnt_out  out  OVF_W  count of words dropped, saturating

Behaviour:
- Reset (async, active-high): shift register=0, bit_cnt=0, pointers=0, len_out=0, overflow_cnt_out=0. After reset: data_out=0, valid_out=0, status_out=0, almost_full_out=(AFULL_LVL==0).
- Receive FSM has two states, IDLE (bit_cnt==0) and SHIFT (bit_cnt 1..DATA_W-1).
  - A write_in edge samples data_in and increments bit_cnt.
  - If write_in arrives with bit_cnt==DATA_W-1, the word is complete. The complete word includes this final bit. bit_cnt returns to 0 (IDLE).
  - When write_in=0, the partial word is held indefinitely. There is no timeout.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Enqueue: performed on the same edge that completes the word.
  - With an empty queue, data_out/valid_out update after that edge, giving 1-cycle latency from the final bit.
- Dequeue: dequeue_in=1 with valid_out=1 advances the head. The next word appears on data_out after that edge. dequeue_in while empty is ignored; len_out does not underflow.
- Simultaneous completion and dequeue:
  - Not full: both operations happen and len_out is unchanged.
  - Full: the dequeue frees a slot and the new word is accepted, with no drop.
  - Empty: the word is enqueued and the dequeue is ignored.
- Overflow: a word completes while full with no dequeue. The word is dropped, the queue is unchanged, and overflow_cnt_out increments, saturating at 2^OVF_W-1.
- Pointers wrap explicitly at DEPTH-1 -> 0. Do not rely on power-of-two rollover.
- flush_in has highest priority below reset:
  - Clears pointers, len_out and the partial word (bit_cnt=0) on that edge.
  - write_in and dequeue_in in the same cycle are ignored.
  - overflow_cnt_out is kept; only reset clears it.
- Flags are combinational from registered len_out. status_out and almost_full_out must never glitch on a non-changing len_out.
- Reset asserted mid-word or mid-burst discards all content immediately, without waiting for a clock.

Decomposition:
- Package deser_pkg:
  - Default DATA_W/DEPTH constants.
  - Length-width localparam helper.
  - rx_state_t enum {RX_IDLE, RX_SHIFT}.
- Sub-module fila_param (DATA_W, DEPTH):
  - Ports: enqueue, dequeue, flush, FWFT head, len, full/empty.
  - Carries the storage array, pointers and wrap logic.
- deser_fila_param keeps the shift register, bit counter, bit-order mux, overflow counter and flags.

Test Plan:
- Reset then bits 1,0,1,1,0,0,1,0 (MSB_FIRST=1) -> one cycle after the 8th bit: valid_out=1, data_out=8'hB2, len_out=1.
- Same bits with MSB_FIRST=0 -> data_out=8'h4D; dequeue_in one cycle -> valid_out=0, data_out=0, len_out=0.
- Push 8 words 8'h01..8'h08 without dequeue -> status_out=1 after the 8th word, almost_full_out=1 from the 6th word; a 9th word 8'hFF -> dropped, overflow_cnt_out=1; dequeue yields 01..08 in order.
- Queue full; 9th word's final bit on the same edge as dequeue_in -> head 01 removed, 8'hFF accepted, len_out stays 8, overflow_cnt_out unchanged.
- 5 bits of a partial word then flush_in with write_in=1 -> bit_cnt=0, len_out=0; the next 8 bits form a clean word with no leftover bits.
- DEPTH=5 build: 12 push/pop pairs interleaved -> pointers wrap, data order preserved, len_out never exceeds 5; reset pulsed mid-word -> all outputs return to reset values asynchronously.
